// File: rtl/mdu_hilo_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master; mdu_hilo is the slave.
interface mdu_hilo_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Multiply has a fixed latency; divide is a radix-2 restoring loop plus a sign-fix cycle.
module mdu_hilo #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              idle_s, accept_s, is_mul_s, is_div_s, dz_s;
  logic              op_sgn_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic              mul_sgn_s;
  logic [XLEN-1:0]   ma_s, mb_s;
  logic [2*XLEN-1:0] ma_ext_s, mb_ext_s, prod_s;
  logic [2*XLEN-1:0] step_init_s, step_iter_s;

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] r_n;
    logic [XLEN-1:0] q_n;
    trial = {r, q[XLEN-1]};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d}) begin
      r_n = diff[XLEN-1:0];
      q_n = {q[XLEN-2:0], 1'b1};
    end else begin
      r_n = trial[XLEN-1:0];
      q_n = {q[XLEN-2:0], 1'b0};
    end
    return {r_n, q_n};
  endfunction

  assign idle_s   = (state_q == S_IDLE);
  assign accept_s = idle_s & bus.start & ~bus.flush;
  assign is_mul_s = accept_s & (bus.op[2:1] == 2'b00);
  assign is_div_s = accept_s & (bus.op[2:1] == 2'b01);
  assign dz_s     = (bus.rt_val == {XLEN{1'b0}});

  // op bit 0 clear selects the signed variant for both multiply and divide
  assign op_sgn_s = ~bus.op[0];
  assign a_neg_s  = op_sgn_s & bus.rs_val[XLEN-1];
  assign b_neg_s  = op_sgn_s & bus.rt_val[XLEN-1];
  assign a_mag_s  = a_neg_s ? (-bus.rs_val) : bus.rs_val;
  assign b_mag_s  = b_neg_s ? (-bus.rt_val) : bus.rt_val;

  // With MUL_LAT==1 the product is written at accept, straight from the live operands.
  assign mul_sgn_s = idle_s ? op_sgn_s : sgn_q;
  assign ma_s      = idle_s ? bus.rs_val : a_q;
  assign mb_s      = idle_s ? bus.rt_val : b_q;
  assign ma_ext_s  = {{XLEN{mul_sgn_s & ma_s[XLEN-1]}}, ma_s};
  assign mb_ext_s  = {{XLEN{mul_sgn_s & mb_s[XLEN-1]}}, mb_s};
  assign prod_s    = ma_ext_s * mb_ext_s;

  assign step_init_s = div_step({XLEN{1'b0}}, a_mag_s, b_mag_s);
  assign step_iter_s = div_step(rem_q, quo_q, b_q);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {XLEN{1'b0}};
      b_q     <= {XLEN{1'b0}};
      sgn_q   <= 1'b0;
      rem_q   <= {XLEN{1'b0}};
      quo_q   <= {XLEN{1'b0}};
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; flush returns any busy state to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul_s && (MUL_LAT > 1)) begin
          state_d = S_MUL;
        end else if (is_div_s && !dz_s) begin
          state_d = S_DIV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (bus.flush || (cnt_q == CNT_ONE)) state_d = S_IDLE;
        else                                 state_d = S_MUL;
      end
      S_DIV: begin
        if (bus.flush)               state_d = S_IDLE;
        else if (cnt_q == CNT_ONE)   state_d = S_FIX;
        else                         state_d = S_DIV;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    negq_d = negq_q;
    negr_d = negr_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (bus.op)
            3'd0, 3'd1: begin
              a_d   = bus.rs_val;
              b_d   = bus.rt_val;
              sgn_d = op_sgn_s;
              cnt_d = MUL_CNT;
              if (MUL_LAT == 1) begin
                hi_d   = prod_s[2*XLEN-1:XLEN];
                lo_d   = prod_s[XLEN-1:0];
                done_d = 1'b1;
              end else begin
                done_d = 1'b0;
              end
            end
            3'd2, 3'd3: begin
              if (dz_s) begin
                hi_d   = bus.rs_val;
                lo_d   = {XLEN{1'b1}};
                done_d = 1'b1;
              end else begin
                // first quotient bit is produced at accept; DIV state does the rest
                rem_d  = step_init_s[2*XLEN-1:XLEN];
                quo_d  = step_init_s[XLEN-1:0];
                b_d    = b_mag_s;
                negq_d = a_neg_s ^ b_neg_s;
                negr_d = a_neg_s;
                cnt_d  = DIV_CNT;
              end
            end
            3'd4:    hi_d = bus.rs_val;
            3'd5:    lo_d = bus.rs_val;
            default: done_d = 1'b0;
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      S_MUL: begin
        if (!bus.flush && (cnt_q == CNT_ONE)) begin
          hi_d   = prod_s[2*XLEN-1:XLEN];
          lo_d   = prod_s[XLEN-1:0];
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DIV: begin
        rem_d = step_iter_s[2*XLEN-1:XLEN];
        quo_d = step_iter_s[XLEN-1:0];
        cnt_d = cnt_q - CNT_ONE;
      end
      S_FIX: begin
        if (!bus.flush) begin
          hi_d   = negr_q ? (-rem_q) : rem_q;
          lo_d   = negq_q ? (-quo_q) : quo_q;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo (XLEN=32, MUL_LAT=2).
// Cycle 0 is the cycle in which start is held high; samples are taken 1ns after each posedge.
module tb_mdu_hilo;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic flag;

  mdu_hilo_if #(.XLEN(XLEN)) bus ();

  mdu_hilo #(.XLEN(XLEN), .MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one-cycle start; returns in cycle 1 with start dropped and operands scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    tick();
    bus.start  = 1'b0;
    bus.op     = 3'd6;
    bus.rs_val = 32'hA5A5_5A5A;
    bus.rt_val = 32'h0000_0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.flush = 1'b0;
    ticks(2);
    rst = 1'b0;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    // MULT -2 * 3, then a back-to-back MULTU issued in the completion cycle
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_c1_busy", {62'd0, bus.busy, bus.done}, 64'd2);
    tick();
    chk("mult_c2_flags", {62'd0, bus.busy, bus.done}, 64'd1);
    chk("mult_c2_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'd1, 32'd6, 32'd7);
    chk("b2b_c1_flags", {62'd0, bus.busy, bus.done}, 64'd2);
    tick();
    chk("b2b_c2_hilo", {bus.hi, bus.lo}, 64'd42);
    chk("b2b_c2_done", {63'd0, bus.done}, 64'd1);
    tick();
    chk("b2b_c3_done", {63'd0, bus.done}, 64'd0);

    // MULTU all-ones squared
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    chk("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // DIVU 100/7 with an ignored MULTU issued while busy
    issue(3'd3, 32'd100, 32'd7);
    flag = bus.busy;
    bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    tick();
    bus.start = 1'b0; bus.op = 3'd6;
    for (int c = 2; c <= 32; c++) begin
      flag = flag & bus.busy & ~bus.done;
      if (c < 32) tick();
    end
    chk("divu_busy_1_32", {63'd0, flag}, 64'd1);
    tick();
    chk("divu_c33_flags", {62'd0, bus.busy, bus.done}, 64'd1);
    chk("divu_c33_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
    tick();
    chk("divu_ignored_start", {62'd0, bus.busy, bus.done}, 64'd0);

    // DIV -7/2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    ticks(32);
    chk("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_neg_done", {63'd0, bus.done}, 64'd1);

    // DIV most-negative by -1
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    ticks(32);
    chk("div_ovf_hilo", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

    // DIV by zero
    issue(3'd2, 32'd5, 32'd0);
    chk("dz_c1_flags", {62'd0, bus.busy, bus.done}, 64'd1);
    chk("dz_c1_hilo", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});

    // MTHI / MTLO, then flushed DIVU
    issue(3'd4, 32'h11, 32'd0);
    chk("mthi_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("mthi_hilo", {bus.hi, bus.lo}, {32'h11, 32'hFFFF_FFFF});
    issue(3'd5, 32'h22, 32'd0);
    chk("mtlo_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});
    issue(3'd3, 32'd100, 32'd7);
    ticks(9);
    chk("flush_c10_busy", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_c11_busy", {63'd0, bus.busy}, 64'd0);
    flag = 1'b0;
    for (int c = 0; c < 30; c++) begin
      flag = flag | bus.done | bus.busy;
      tick();
    end
    chk("flush_no_done", {63'd0, flag}, 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, {32'h11, 32'h22});

    // flush together with start: start dropped
    bus.flush = 1'b1;
    issue(3'd4, 32'h77, 32'd0);
    bus.flush = 1'b0;
    chk("flush_start_drop", {bus.hi, bus.lo}, {32'h11, 32'h22});
    chk("flush_start_busy", {63'd0, bus.busy}, 64'd0);

    // MTHI DEADBEEF; then no-op opcode 7
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_dead", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'h22});
    issue(3'd7, 32'h1234_5678, 32'd3);
    chk("nop_hilo", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'h22});
    chk("nop_flags", {62'd0, bus.busy, bus.done}, 64'd0);

    // reset mid-divide
    issue(3'd3, 32'd1000, 32'd3);
    ticks(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    ticks(40);
    chk("rst_mid_after", {bus.hi, bus.lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
